// File: rtl/tract_pkg.sv
// Shared types and lane constants for the RV32I memory stage.
// Encodings of the result/store/load selectors driven from execute.
package tract_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    ST_SW = 2'b00,
    ST_SH = 2'b01,
    ST_SB = 2'b10
  } store_src_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LB  = 3'b010,
    LD_LHU = 3'b011,
    LD_LBU = 3'b100
  } load_src_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Byte-enable seeds, shifted left by the lane offset.
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_BYTE = 4'b0001;

endpackage

// File: rtl/tract_load_ext.sv
// Load extraction: picks the addressed byte/halfword and extends it.
// Reserved load encodings fall through to a full-word pass-through.
module tract_load_ext
  import tract_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_src,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    value = rdata;
    case (load_src)
      LD_LH:   value = {{16{half_sel[15]}}, half_sel};
      LD_LB:   value = {{24{byte_sel[7]}}, byte_sel};
      LD_LHU:  value = {16'h0000, half_sel};
      LD_LBU:  value = {24'h000000, byte_sel};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/tract_mem_stage.sv
// RV32I memory stage: E/M and M/W registers, dmem handshake with timeout.
// Optional misaligned-access trap enabled by TRACT_MISALIGN_TRAP_EN.
module tract_mem_stage
  import tract_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic [1:0]      StoreSrcE,
  input  logic [2:0]      LoadSrcE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ready,
  output logic            StallM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] PCPlus4W,
`ifdef TRACT_MISALIGN_TRAP_EN
  output logic            bus_err,
  output logic            misalign_m
`else
  output logic            bus_err
`endif
);

  logic [1:0]      result_src_m;
  logic            mem_write_m;
  logic [1:0]      store_src_m;
  logic [2:0]      load_src_m;
  logic [XLEN-1:0] write_data_m;
  logic [XLEN-1:0] pc_plus4_m;

  mem_state_t      state, state_n;
  logic [CNT_W-1:0] wait_cnt, cnt_n;
  logic            mem_op, is_load, misalign, timeout;
  logic [1:0]      a;
  logic [XLEN-1:0] rdata_sel, load_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM    <= 1'b0;
      result_src_m <= 2'b00;
      mem_write_m  <= 1'b0;
      store_src_m  <= 2'b00;
      load_src_m   <= 3'b000;
      ALUResultM   <= '0;
      write_data_m <= '0;
      RdM          <= 5'd0;
      pc_plus4_m   <= '0;
    end else if (!StallM) begin
      RegWriteM    <= RegWriteE;
      result_src_m <= ResultSrcE;
      mem_write_m  <= MemWriteE;
      store_src_m  <= StoreSrcE;
      load_src_m   <= LoadSrcE;
      ALUResultM   <= ALUResultE;
      write_data_m <= WriteDataE;
      RdM          <= RdE;
      pc_plus4_m   <= PCPlus4E;
    end
  end

  assign a       = ALUResultM[1:0];
  assign is_load = (result_src_m == RES_LOAD);
  assign mem_op  = mem_write_m | is_load;

`ifdef TRACT_MISALIGN_TRAP_EN
  logic st_word, ld_word, ld_half;
  assign st_word  = (store_src_m != ST_SH) && (store_src_m != ST_SB);
  assign ld_half  = (load_src_m == LD_LH) || (load_src_m == LD_LHU);
  assign ld_word  = !ld_half && (load_src_m != LD_LB) && (load_src_m != LD_LBU);
  assign misalign = mem_write_m ? ((st_word && a != 2'b00) || (store_src_m == ST_SH && a[0]))
                  : is_load && ((ld_word && a != 2'b00) || (ld_half && a[0]));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= cnt_n;
      bus_err  <= bus_err | timeout;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = wait_cnt;
    dmem_req = 1'b0;
    StallM   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        dmem_req = mem_op & ~misalign;
        if (dmem_req && !dmem_ready) begin
          StallM  = 1'b1;
          state_n = WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_n = IDLE;
        end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
          // Give up: complete with zero data and flag the bus error.
          timeout = 1'b1;
          state_n = IDLE;
        end else begin
          StallM = 1'b1;
          cnt_n  = wait_cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign dmem_we   = mem_write_m & dmem_req;
  assign dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_be    = BE_WORD;
    dmem_wdata = write_data_m;
    if (mem_write_m) begin
      case (store_src_m)
        ST_SH: begin
          dmem_be    = BE_HALF << {a[1], 1'b0};
          dmem_wdata = {2{write_data_m[15:0]}};
        end
        ST_SB: begin
          dmem_be    = BE_BYTE << a;
          dmem_wdata = {4{write_data_m[7:0]}};
        end
        default: begin
          dmem_be    = BE_WORD;
          dmem_wdata = write_data_m;
        end
      endcase
    end
  end

  assign rdata_sel = timeout ? '0 : dmem_rdata;

  tract_load_ext u_load_ext (
    .rdata    (rdata_sel),
    .offset   (a),
    .load_src (load_src_m),
    .value    (load_val)
  );

  // A stall cycle pushes a zeroed bubble into W.
  always_ff @(posedge clk) begin
    if (reset || StallM) begin
      RegWriteW  <= 1'b0;
      ResultSrcW <= 2'b00;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      RdW        <= 5'd0;
      PCPlus4W   <= '0;
    end else begin
      RegWriteW  <= RegWriteM & ~misalign;
      ResultSrcW <= result_src_m;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_val;
      RdW        <= RdM;
      PCPlus4W   <= pc_plus4_m;
    end
  end

`ifdef TRACT_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset || StallM) misalign_m <= 1'b0;
    else                 misalign_m <= misalign & mem_op;
  end
`endif

endmodule
